// File: rtl/gpio_ctrl.sv
// GPIO controller: register-mapped pad outputs, synchronised inputs,
// edge-triggered interrupts with write-one-to-clear status.
module gpio_ctrl #(
  parameter int NUM_PINS    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [7:0]          addr_i,
  input  logic [31:0]         wdata_i,
  input  logic [3:0]          be_i,
  output logic                gnt_o,
  output logic                rvalid_o,
  output logic [31:0]         rdata_o,
  output logic                err_o,
  input  logic [NUM_PINS-1:0] gpio_i,
  output logic [NUM_PINS-1:0] gpio_o,
  output logic [NUM_PINS-1:0] gpio_oe_o,
  output logic                irq_o
);

  typedef logic [NUM_PINS-1:0] pins_t;

  pins_t dout_q, dir_q, en_rise_q, en_fall_q, status_q;
  pins_t dout_n, dir_n, en_rise_n, en_fall_n, status_n;
  pins_t sync_r [SYNC_STAGES];
  pins_t sync_q, prev_q, rise, fall, ev, clr, m, wd;

  logic [5:0]  idx;
  logic        mapped;
  logic [31:0] bmask, rd;
  logic        rvalid_q, err_q;
  logic [31:0] rdata_q;

  assign idx    = addr_i[7:2];
  assign mapped = (idx <= 6'd8);
  assign bmask  = {{8{be_i[3]}}, {8{be_i[2]}},
                   {8{be_i[1]}}, {8{be_i[0]}}};
  assign m      = bmask[NUM_PINS-1:0];
  assign wd     = wdata_i[NUM_PINS-1:0] & m;

  assign sync_q = sync_r[SYNC_STAGES-1];
  assign rise   = sync_q & ~prev_q;
  assign fall   = ~sync_q & prev_q;
  assign ev     = (rise & en_rise_q) | (fall & en_fall_q);

  // Next-state of the writable registers; a pending event beats W1C.
  always_comb begin
    dout_n    = dout_q;
    dir_n     = dir_q;
    en_rise_n = en_rise_q;
    en_fall_n = en_fall_q;
    clr       = '0;
    if (req_i && we_i) begin
      unique case (idx)
        6'd0:    dout_n    = (dout_q & ~m) | wd;
        6'd1:    dir_n     = (dir_q & ~m) | wd;
        6'd3:    dout_n    = dout_q | wd;
        6'd4:    dout_n    = dout_q & ~wd;
        6'd5:    dout_n    = dout_q ^ wd;
        6'd6:    en_rise_n = (en_rise_q & ~m) | wd;
        6'd7:    en_fall_n = (en_fall_q & ~m) | wd;
        6'd8:    clr       = wd;
        default: ;
      endcase
    end
    status_n = (status_q & ~clr) | ev;
  end

  // Read mux on pre-edge register values, zero-extended to 32 bits.
  always_comb begin
    rd = '0;
    if (req_i && !we_i) begin
      unique case (idx)
        6'd0:    rd[NUM_PINS-1:0] = dout_q;
        6'd1:    rd[NUM_PINS-1:0] = dir_q;
        6'd2:    rd[NUM_PINS-1:0] = sync_q;
        6'd6:    rd[NUM_PINS-1:0] = en_rise_q;
        6'd7:    rd[NUM_PINS-1:0] = en_fall_q;
        6'd8:    rd[NUM_PINS-1:0] = status_q;
        default: rd = '0;
      endcase
    end
  end

  // Register file and bus response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_q    <= '0;
      dir_q     <= '0;
      en_rise_q <= '0;
      en_fall_q <= '0;
      status_q  <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      dout_q    <= dout_n;
      dir_q     <= dir_n;
      en_rise_q <= en_rise_n;
      en_fall_q <= en_fall_n;
      status_q  <= status_n;
      rvalid_q  <= req_i;
      err_q     <= req_i & ~mapped;
      rdata_q   <= rd;
    end
  end

  // Input synchroniser chain and edge-detect history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_r[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_r[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_r[i] <= sync_r[i-1];
      prev_q <= sync_q;
    end
  end

  assign gnt_o     = req_i;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;
  assign gpio_o    = dout_q;
  assign gpio_oe_o = dir_q;
  assign irq_o     = |status_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Randomised bench for gpio_ctrl against a cycle-level behavioural model,
// plus directed scenarios including an 8-pin instance.
module tb_gpio_ctrl;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic [31:0] gpio = '0;

  logic        gnt, rvalid, err, irq;
  logic [31:0] rdata, gpio_o, gpio_oe;
  logic        gnt8, rvalid8, err8, irq8;
  logic [31:0] rdata8;
  logic [7:0]  gpio_o8, gpio_oe8;

  int n_checks = 0;
  int n_pass = 0;

  gpio_ctrl #(.NUM_PINS(32), .SYNC_STAGES(S)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .err_o(err), .gpio_i(gpio), .gpio_o(gpio_o),
    .gpio_oe_o(gpio_oe), .irq_o(irq)
  );

  gpio_ctrl #(.NUM_PINS(8), .SYNC_STAGES(S)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt8), .rvalid_o(rvalid8), .rdata_o(rdata8),
    .err_o(err8), .gpio_i(gpio[7:0]), .gpio_o(gpio_o8),
    .gpio_oe_o(gpio_oe8), .irq_o(irq8)
  );

  always #5 clk = ~clk;

  logic [31:0] m_dout, m_dir, m_er, m_ef, m_st, m_prev, m_rd;
  logic        m_rv, m_err;
  logic [31:0] pipe [$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_dout = '0; m_dir = '0; m_er = '0; m_ef = '0;
    m_st = '0; m_prev = '0; m_rd = '0;
    m_rv = 1'b0; m_err = 1'b0;
    pipe.delete();
    for (int i = 0; i < S; i++) pipe.push_back('0);
  endtask

  // Apply one clock edge to the model, then compare after the edge.
  task automatic tick();
    logic [31:0] sq, ev, msk, wd, clr;
    int off;
    chk("gnt", {31'b0, gnt}, {31'b0, req});
    if (rst) begin
      model_reset();
    end else begin
      sq  = pipe[0];
      ev  = (sq & ~m_prev & m_er) | (~sq & m_prev & m_ef);
      msk = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      wd  = wdata & msk;
      off = int'(addr) / 4;
      clr = '0;
      m_rv  = req;
      m_err = req && off > 8;
      m_rd  = '0;
      if (req && !we) begin
        case (off)
          0: m_rd = m_dout;
          1: m_rd = m_dir;
          2: m_rd = sq;
          6: m_rd = m_er;
          7: m_rd = m_ef;
          8: m_rd = m_st;
          default: m_rd = '0;
        endcase
      end
      if (req && we) begin
        case (off)
          0: m_dout = (m_dout & ~msk) | wd;
          1: m_dir  = (m_dir & ~msk) | wd;
          3: m_dout = m_dout | wd;
          4: m_dout = m_dout & ~wd;
          5: m_dout = m_dout ^ wd;
          6: m_er   = (m_er & ~msk) | wd;
          7: m_ef   = (m_ef & ~msk) | wd;
          8: clr    = wd;
          default: ;
        endcase
      end
      m_st = (m_st & ~clr) | ev;
      m_prev = sq;
      pipe.push_back(gpio);
      void'(pipe.pop_front());
    end
    @(posedge clk);
    #1;
    chk("gpio_o", gpio_o, m_dout);
    chk("gpio_oe", gpio_oe, m_dir);
    chk("irq", {31'b0, irq}, {31'b0, (m_st != 0)});
    chk("rvalid", {31'b0, rvalid}, {31'b0, m_rv});
    chk("err", {31'b0, err}, {31'b0, m_err});
    if (m_rv) chk("rdata", rdata, m_rd);
  endtask

  task automatic idle(input int n);
    req = 1'b0; we = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus(input logic w, input logic [7:0] a,
                     input logic [31:0] d, input logic [3:0] b);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    tick();
    req = 1'b0; we = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    idle(3);
    chk("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    idle(2);

    bus(1, 8'h04, 32'hFFFF_FFFF, 4'hF);
    bus(1, 8'h00, 32'h0000_001E, 4'hF);
    chk("oe_all", gpio_oe, 32'hFFFF_FFFF);
    chk("out_30", gpio_o, 32'd30);
    bus(0, 8'h00, 32'h0, 4'hF);
    chk("rd_dout", rdata, 32'h1E);

    bus(1, 8'h00, 32'h0F, 4'hF);
    bus(1, 8'h0C, 32'hF0, 4'hF);
    chk("set", gpio_o, 32'hFF);
    bus(1, 8'h10, 32'h03, 4'hF);
    chk("clr", gpio_o, 32'hFC);
    bus(1, 8'h14, 32'h101, 4'hF);
    chk("tog", gpio_o, 32'h1FD);
    bus(0, 8'h0C, 32'h0, 4'hF);
    chk("rd_set0", rdata, 32'h0);

    bus(1, 8'h18, 32'h1, 4'hF);
    gpio[0] = 1'b1;
    for (int i = 1; i <= S + 1; i++) begin
      tick();
      chk("irq_lat", {31'b0, irq}, {31'b0, (i == S + 1)});
    end
    bus(1, 8'h20, 32'h1, 4'hF);
    chk("irq_w1c", {31'b0, irq}, 32'h0);

    gpio[2] = 1'b1;
    idle(S + 2);
    bus(1, 8'h1C, 32'h4, 4'hF);
    gpio[2] = 1'b0;
    idle(S);
    bus(1, 8'h20, 32'h4, 4'hF);
    bus(0, 8'h20, 32'h0, 4'hF);
    chk("set_wins", rdata & 32'h4, 32'h4);

    bus(1, 8'h00, 32'h0, 4'hF);
    bus(1, 8'h00, 32'hAABB_CCDD, 4'h5);
    chk("be_mask", gpio_o, 32'h00BB_00DD);
    bus(0, 8'h40, 32'h0, 4'hF);
    chk("unmap_rd", rdata, 32'h0);
    chk("unmap_err", {31'b0, err}, 32'h1);

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(199) == 0);
      req = ($urandom_range(3) != 0);
      we = $urandom_range(1);
      if ($urandom_range(9) == 0) addr = 8'($urandom);
      else addr = {3'($urandom_range(0, 8)), 2'b00} |
                  8'($urandom_range(3));
      wdata = $urandom;
      be = 4'($urandom);
      if ($urandom_range(2) == 0)
        gpio = gpio ^ (32'h1 << $urandom_range(31));
      tick();
    end
    rst = 1'b0;

    idle(1);
    bus(1, 8'h00, 32'hFFFF_FFFF, 4'hF);
    bus(1, 8'h04, 32'hFFFF_FFFF, 4'hF);
    bus(0, 8'h00, 32'h0, 4'hF);
    chk("p8_rd", rdata8, 32'h0000_00FF);
    chk("p8_oe", {24'b0, gpio_oe8}, 32'hFF);
    rst = 1'b1;
    req = 1'b1; we = 1'b0; addr = 8'h00;
    tick();
    rst = 1'b0;
    req = 1'b0;
    chk("p8_rst_out", {24'b0, gpio_o8}, 32'h0);
    chk("p8_rst_oe", {24'b0, gpio_oe8}, 32'h0);
    chk("p8_rst_misc", {28'b0, rvalid8, err8, irq8, |rdata8}, 32'h0);
    tick();
    chk("p8_no_rv", {31'b0, rvalid8}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
